// File: rtl/song_sequencer_if.sv
// Control bundle between the front panel / codec / song reader and song_sequencer.
// The master side drives buttons, frame strobe and song_done; the slave is the sequencer.
interface song_sequencer_if #(
    parameter int unsigned SONG_W = 2
) ();
    logic              play_button;
    logic              next_button;
    logic              playback_button;
    logic              new_frame;
    logic              song_done;
    logic              play;
    logic              reset_player;
    logic [SONG_W-1:0] song;
    logic              playback;
    logic              busy;

    modport master (
        output play_button, next_button, playback_button, new_frame, song_done,
        input  play, reset_player, song, playback, busy
    );

    modport slave (
        input  play_button, next_button, playback_button, new_frame, song_done,
        output play, reset_player, song, playback, busy
    );
endinterface

// File: rtl/song_sequencer.sv
// Frame-aligned play/pause/next/playback sequencer for the music player.
// Button and song_done pulses are latched and only acted on at a new_frame strobe,
// so the song reader never changes state in the middle of an audio sample.
// Optional macro SONG_SEQ_AUTO_ADVANCE_EN: a finished song advances to the next one and
// keeps playing; otherwise it is rewound and paused.
module song_sequencer #(
    parameter int unsigned NUM_SONGS    = 4,
    parameter int unsigned SONG_W       = 2,
    parameter int unsigned RESET_CYCLES = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    song_sequencer_if.slave bus_io
);
    localparam int unsigned CntW = $clog2(RESET_CYCLES + 1);

    typedef enum logic [1:0] {StPaused, StPlaying, StResetting} state_e;

    state_e            r_state, w_state_nxt;
    state_e            r_ret_state, w_ret_nxt;
    logic [CntW-1:0]   r_cnt, w_cnt_nxt;
    logic [SONG_W-1:0] r_song, w_song_nxt, w_song_inc;
    logic              r_playback, w_playback_nxt;
    logic              r_p_play, r_p_next, r_p_pb, r_p_done;
    logic              w_p_play_nxt, w_p_next_nxt, w_p_pb_nxt, w_p_done_nxt;
    logic              w_take_play, w_take_next, w_take_pb, w_take_done;
    logic              r_play, r_reset_player, r_busy;

    // Next-state decode: at most one latched command consumed per frame, done > next > play > pb
    always_comb begin
        w_state_nxt    = r_state;
        w_ret_nxt      = r_ret_state;
        w_cnt_nxt      = r_cnt;
        w_song_nxt     = r_song;
        w_playback_nxt = r_playback;
        w_take_play    = 1'b0;
        w_take_next    = 1'b0;
        w_take_pb      = 1'b0;
        w_take_done    = 1'b0;
        // Explicit compare so non-power-of-two song counts wrap correctly
        w_song_inc     = (r_song == SONG_W'(NUM_SONGS - 1)) ? '0 : r_song + SONG_W'(1);

        unique case (r_state)
            StPaused: begin
                if (bus_io.new_frame) begin
                    if (r_p_next) begin
                        w_take_next = 1'b1;
                        w_song_nxt  = w_song_inc;
                        w_ret_nxt   = StPaused;
                        w_state_nxt = StResetting;
                        w_cnt_nxt   = CntW'(RESET_CYCLES - 1);
                    end else if (r_p_play) begin
                        w_take_play = 1'b1;
                        w_state_nxt = StPlaying;
                    end else if (r_p_pb) begin
                        w_take_pb      = 1'b1;
                        w_playback_nxt = ~r_playback;
                        w_ret_nxt      = StPaused;
                        w_state_nxt    = StResetting;
                        w_cnt_nxt      = CntW'(RESET_CYCLES - 1);
                    end
                end
            end
            StPlaying: begin
                // Playback toggles are deferred until paused
                if (bus_io.new_frame) begin
                    if (r_p_done) begin
                        w_take_done = 1'b1;
                        w_state_nxt = StResetting;
                        w_cnt_nxt   = CntW'(RESET_CYCLES - 1);
`ifdef SONG_SEQ_AUTO_ADVANCE_EN
                        w_song_nxt  = w_song_inc;
                        w_ret_nxt   = StPlaying;
`else
                        w_ret_nxt   = StPaused;
`endif
                    end else if (r_p_next) begin
                        w_take_next = 1'b1;
                        w_song_nxt  = w_song_inc;
                        w_ret_nxt   = StPaused;
                        w_state_nxt = StResetting;
                        w_cnt_nxt   = CntW'(RESET_CYCLES - 1);
                    end else if (r_p_play) begin
                        w_take_play = 1'b1;
                        w_state_nxt = StPaused;
                    end
                end
            end
            StResetting: begin
                // Leaves after exactly RESET_CYCLES cycles, independent of new_frame
                if (r_cnt == '0) begin
                    w_state_nxt = r_ret_state;
                end else begin
                    w_cnt_nxt = r_cnt - CntW'(1);
                end
            end
            default: w_state_nxt = StPaused;
        endcase

        // A pulse in the consume cycle re-arms the latch so it is not lost
        w_p_play_nxt = (r_p_play & ~w_take_play) | bus_io.play_button;
        w_p_next_nxt = (r_p_next & ~w_take_next) | bus_io.next_button;
        w_p_pb_nxt   = (r_p_pb   & ~w_take_pb)   | bus_io.playback_button;
        // song_done only matters while playing; pausing discards a stale one
        w_p_done_nxt = (r_state == StPlaying) &
                       ((r_p_done & ~w_take_done & ~w_take_play) | bus_io.song_done);
    end

    // State, latches and outputs registered from the decoded next state
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state        <= StPaused;
            r_ret_state    <= StPaused;
            r_cnt          <= '0;
            r_song         <= '0;
            r_playback     <= 1'b0;
            r_p_play       <= 1'b0;
            r_p_next       <= 1'b0;
            r_p_pb         <= 1'b0;
            r_p_done       <= 1'b0;
            r_play         <= 1'b0;
            r_reset_player <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_ret_state    <= w_ret_nxt;
            r_cnt          <= w_cnt_nxt;
            r_song         <= w_song_nxt;
            r_playback     <= w_playback_nxt;
            r_p_play       <= w_p_play_nxt;
            r_p_next       <= w_p_next_nxt;
            r_p_pb         <= w_p_pb_nxt;
            r_p_done       <= w_p_done_nxt;
            r_play         <= (w_state_nxt == StPlaying);
            r_reset_player <= (w_state_nxt == StResetting);
            r_busy         <= (w_state_nxt == StResetting);
        end
    end

    assign bus_io.play         = r_play;
    assign bus_io.reset_player = r_reset_player;
    assign bus_io.song         = r_song;
    assign bus_io.playback     = r_playback;
    assign bus_io.busy         = r_busy;
endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer (3 songs, 4-cycle reset_player pulse).
module tb_song_sequencer;
    localparam int unsigned NumSongs    = 3;
    localparam int unsigned SongW       = 2;
    localparam int unsigned ResetCycles = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    song_sequencer_if #(.SONG_W(SongW)) u_if ();

    song_sequencer #(
        .NUM_SONGS   (NumSongs),
        .SONG_W      (SongW),
        .RESET_CYCLES(ResetCycles)
    ) u_dut (
        .i_clk  (clk),
        .i_reset(reset_n),
        .bus_io (u_if)
    );

    always #5 clk = ~clk;

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic pl, input logic nx, input logic pb, input logic dn);
        u_if.play_button     = pl;
        u_if.next_button     = nx;
        u_if.playback_button = pb;
        u_if.song_done       = dn;
        tick();
        u_if.play_button     = 1'b0;
        u_if.next_button     = 1'b0;
        u_if.playback_button = 1'b0;
        u_if.song_done       = 1'b0;
    endtask

    task automatic frame();
        u_if.new_frame = 1'b1;
        tick();
        u_if.new_frame = 1'b0;
    endtask

    // Counts reset_player/busy/play over 8 cycles starting with the current sample
    task automatic run_reset(output int rp, output int bz, output int pl);
        rp = 0;
        bz = 0;
        pl = 0;
        for (int i = 0; i < 8; i++) begin
            rp += int'(u_if.reset_player);
            bz += int'(u_if.busy);
            pl += int'(u_if.play);
            tick();
        end
    endtask

    initial begin
        int   rp, bz, pl;
        logic early;
        logic [SongW-1:0] exp_song;

        u_if.play_button     = 1'b0;
        u_if.next_button     = 1'b0;
        u_if.playback_button = 1'b0;
        u_if.new_frame       = 1'b0;
        u_if.song_done       = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_play", u_if.play, 0);
        check("rst_song", u_if.song, 0);
        check("rst_playback", u_if.playback, 0);
        check("rst_reset_player", u_if.reset_player, 0);
        check("rst_busy", u_if.busy, 0);
        reset_n = 1'b1;
        tick();

        // Frame alignment: play_button at 10, frame at 100, play rises at 101
        early = 1'b0;
        for (int c = 0; c <= 100; c++) begin
            u_if.new_frame   = (c == 100);
            u_if.play_button = (c == 10);
            tick();
            if (c < 100) early |= u_if.play;
        end
        u_if.new_frame   = 1'b0;
        u_if.play_button = 1'b0;
        check("align_no_early_play", early, 0);
        check("align_play_at_101", u_if.play, 1);

        // Simultaneous next+play while playing song 0
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        frame();
        check("simul_song", u_if.song, 1);
        check("simul_busy", u_if.busy, 1);
        check("simul_play_low", u_if.play, 0);
        run_reset(rp, bz, pl);
        check("simul_rp_cycles", rp, ResetCycles);
        check("simul_paused", u_if.play, 0);
        frame();
        check("simul_play_next_frame", u_if.play, 1);

        // Playback deferred while playing
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        frame();
        check("pb_defer_playback", u_if.playback, 0);
        check("pb_defer_busy", u_if.busy, 0);
        check("pb_defer_play", u_if.play, 1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        frame();
        check("pb_pause_play", u_if.play, 0);
        check("pb_pause_playback", u_if.playback, 0);
        frame();
        check("pb_toggle", u_if.playback, 1);
        check("pb_reset_player", u_if.reset_player, 1);
        run_reset(rp, bz, pl);
        check("pb_rp_cycles", rp, ResetCycles);
        check("pb_after_play", u_if.play, 0);

        // Next with wrap: song 1 -> 2 -> 0 -> 1
        exp_song = 2'd1;
        for (int k = 0; k < 3; k++) begin
            exp_song = (exp_song == SongW'(NumSongs - 1)) ? '0 : exp_song + 1'b1;
            pulse(1'b0, 1'b1, 1'b0, 1'b0);
            frame();
            check("next_song", u_if.song, exp_song);
            run_reset(rp, bz, pl);
            check("next_rp_cycles", rp, ResetCycles);
            check("next_busy_cycles", bz, ResetCycles);
            check("next_play_low", pl, 0);
        end

        // Pulse coincident with new_frame waits for the following frame
        u_if.play_button = 1'b1;
        u_if.new_frame   = 1'b1;
        tick();
        u_if.play_button = 1'b0;
        u_if.new_frame   = 1'b0;
        check("coinc_hold", u_if.play, 0);
        frame();
        check("coinc_next_frame", u_if.play, 1);

        // Song done on the last song (playing song 1 -> next -> 2, then play)
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        frame();
        check("done_setup_song", u_if.song, 2);
        run_reset(rp, bz, pl);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        frame();
        check("done_setup_play", u_if.play, 1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        frame();
        check("done_busy", u_if.busy, 1);
`ifdef SONG_SEQ_AUTO_ADVANCE_EN
        check("done_song_wrap", u_if.song, 0);
        run_reset(rp, bz, pl);
        check("done_rp_cycles", rp, ResetCycles);
        check("done_play_after", u_if.play, 1);
`else
        check("done_song_kept", u_if.song, 2);
        run_reset(rp, bz, pl);
        check("done_rp_cycles", rp, ResetCycles);
        check("done_play_after", u_if.play, 0);
`endif

        // Async reset in the middle of RESETTING
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        frame();
        tick();
        check("async_pre_busy", u_if.busy, 1);
        reset_n = 1'b0;
        #1;
        check("async_busy", u_if.busy, 0);
        check("async_reset_player", u_if.reset_player, 0);
        check("async_song", u_if.song, 0);
        check("async_playback", u_if.playback, 0);
        tick();
        reset_n = 1'b1;
        tick();
        frame();
        check("async_no_pending", u_if.busy, 0);
        check("async_play_low", u_if.play, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
